// File: rtl/arima_sample_server.sv
// Memory-side responder for the ARIMA core: circular sample buffer with absolute indexing plus a result FIFO.
// Optional per-event statistics counters are enabled by defining ARIMA_SAMPLE_SERVER_STATS_EN.
module arima_sample_server #(
  parameter int N      = 32,
  parameter int DEPTH  = 64,
  parameter int HIST   = 10,
  parameter int RDEPTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_data,
  input  logic [31:0]   address_r,
  input  logic          rden,
  output logic [N-1:0]  dout,
  output logic          data_ready,
  input  logic [31:0]   address_w,
  input  logic          wren,
  input  logic [N-1:0]  din,
  input  logic          label_in,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [N-1:0]  r_data,
  output logic          r_label,
  output logic [31:0]   r_index,
  output logic          evict_err,
  output logic          res_ovf
`ifdef ARIMA_SAMPLE_SERVER_STATS_EN
  ,
  output logic [31:0]   stat_rd,
  output logic [31:0]   stat_wr,
  output logic [15:0]   stat_drop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RDEPTH);
  localparam int CW = RW + 1;
  localparam int EW = N + 33;
  localparam logic [31:0] HIST_W  = 32'(HIST);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // Both streams use valid/ready: a beat transfers on the rising edge where valid && ready;
  // valid must not depend on ready, and data is held stable while valid is high and ready low.

  logic [N-1:0]  sample_mem [DEPTH];
  logic [EW-1:0] res_mem    [RDEPTH];

  logic [31:0]   wr_cnt, wr_cnt_nxt;
  logic [31:0]   ret, ret_nxt;
  logic [31:0]   oldest, oldest_nxt;
  logic          push;

  logic [RW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, res_push, res_drop;

  function automatic logic [31:0] floor_of(input logic [31:0] r);
    return (r > HIST_W) ? r - HIST_W : 32'd0;
  endfunction

  always_comb begin
    push       = s_valid && s_ready;
    wr_cnt_nxt = wr_cnt + {31'd0, push};
    ret_nxt    = ret;
    if (wren && ((address_w + 32'd1) > ret)) ret_nxt = address_w + 32'd1;
    oldest     = floor_of(ret);
    oldest_nxt = floor_of(ret_nxt);
  end

  assign data_ready = address_r < wr_cnt;

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign full     = count == CW'(RDEPTH);
  assign r_valid  = count != '0;
  assign pop      = r_valid && r_ready;
  assign res_push = wren && (!full || pop);
  assign res_drop = wren && full && !pop;

  assign r_label = res_mem[rd_ptr][EW-1];
  assign r_data  = res_mem[rd_ptr][EW-2:32];
  assign r_index = res_mem[rd_ptr][31:0];

  always_ff @(posedge clk) begin
    if (push)     sample_mem[wr_cnt[AW-1:0]] <= s_data;
    if (res_push) res_mem[wr_ptr]            <= {label_in, din, address_w};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt    <= '0;
      ret       <= '0;
      s_ready   <= 1'b0;
      dout      <= '0;
      evict_err <= 1'b0;
      res_ovf   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      wr_cnt  <= wr_cnt_nxt;
      ret     <= ret_nxt;
      s_ready <= (wr_cnt_nxt - oldest_nxt) < DEPTH_W;
      // Memory is sampled before this edge's push lands, giving read-before-write.
      if (rden) begin
        if (address_r < oldest) begin
          dout      <= '0;
          evict_err <= 1'b1;
        end else if (address_r >= wr_cnt) begin
          dout <= '0;
        end else begin
          dout <= sample_mem[address_r[AW-1:0]];
        end
      end
      if (res_drop) res_ovf <= 1'b1;
      if (res_push) wr_ptr <= wr_ptr + RW'(1);
      if (pop)      rd_ptr <= rd_ptr + RW'(1);
      count <= count + CW'(res_push) - CW'(pop);
    end
  end

`ifdef ARIMA_SAMPLE_SERVER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd   <= '0;
      stat_wr   <= '0;
      stat_drop <= '0;
    end else begin
      if (rden)     stat_rd <= stat_rd + 32'd1;
      if (res_push) stat_wr <= stat_wr + 32'd1;
      if (res_drop && (stat_drop != 16'hFFFF)) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule
